// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed/unsigned divider.
//   - 3-bit state encoding, exposed both as localparams and as the FSM enum
//   - cnt_width(): width of the iteration counter for an N-bit divider
package div_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_NEG_A = 3'd1;
  localparam logic [2:0] ST_NEG_B = 3'd2;
  localparam logic [2:0] ST_ITER  = 3'd3;
  localparam logic [2:0] ST_NEG_Q = 3'd4;
  localparam logic [2:0] ST_NEG_R = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    NEG_A = ST_NEG_A,
    NEG_B = ST_NEG_B,
    ITER  = ST_ITER,
    NEG_Q = ST_NEG_Q,
    NEG_R = ST_NEG_R,
    DONE  = ST_DONE
  } state_t;

  // The counter must be able to hold N-1, with one bit of headroom.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/complement2.sv
// Two's-complement negator: y = -a (modulo 2^N).
// Ports:
//   a  input  [N-1:0]  value to negate
//   y  output [N-1:0]  two's-complement negation of a
module complement2 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = ~a + {{(N-1){1'b0}}, 1'b1};

endmodule

// File: rtl/signed_div_seq.sv
// Sequential restoring divider for signed (two's-complement) or unsigned
// N-bit operands. Signed operands are turned into magnitudes, divided,
// and the results are sign-corrected afterwards, all through a single
// shared negator. Latency is fixed: N+5 cycles, or 1 cycle on divide-by-zero.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request, sampled only when idle
//   is_signed             1 = signed operands, 0 = unsigned
//   dividend, divisor     operands, captured on an accepted start
//   busy                  high whenever the FSM is not idle
//   done                  one-cycle pulse, results valid
//   quotient, remainder   results, held until the next result
//   div_by_zero           divisor was zero for the current result
module signed_div_seq
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  a_reg;      // dividend magnitude, shifted into the quotient
  logic [N-1:0]  b_reg;      // divisor magnitude
  logic [N:0]    rem;        // partial remainder, one guard bit
  logic [CW-1:0] cnt;
  logic          sgn;
  logic          neg_a;      // dividend was negative (signed mode only)
  logic          neg_b;      // divisor was negative (signed mode only)

  logic [N-1:0]  neg_in;
  logic [N-1:0]  neg_out;
  logic [N:0]    shifted;
  logic [N:0]    diff;

  // Select the operand feeding the shared negator for the current state.
  always_comb begin
    neg_in = a_reg;
    case (state)
      NEG_B:   neg_in = b_reg;
      NEG_R:   neg_in = rem[N-1:0];
      default: neg_in = a_reg;   // NEG_A and NEG_Q both work on a_reg
    endcase
  end

  complement2 #(.N(N)) u_neg (
    .a (neg_in),
    .y (neg_out)
  );

  // One restoring step: bring in the next dividend bit, trial-subtract.
  assign shifted = {rem[N-1:0], a_reg[N-1]};
  assign diff    = shifted - {1'b0, b_reg};

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= {N{1'b0}};
      b_reg       <= {N{1'b0}};
      rem         <= {(N+1){1'b0}};
      cnt         <= {CW{1'b0}};
      sgn         <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {N{1'b0}};
      remainder   <= {N{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            sgn   <= is_signed;
            neg_a <= is_signed & dividend[N-1];
            neg_b <= is_signed & divisor[N-1];
            rem   <= {(N+1){1'b0}};
            cnt   <= {CW{1'b0}};
            busy  <= 1'b1;
            if (divisor == {N{1'b0}}) begin
              // Short-circuit: results are defined without iterating.
              quotient    <= {N{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              state <= NEG_A;
            end
          end else begin
            state <= IDLE;
          end
        end
        NEG_A: begin
          if (neg_a) begin
            a_reg <= neg_out;
          end else begin
            a_reg <= a_reg;
          end
          state <= NEG_B;
        end
        NEG_B: begin
          if (neg_b) begin
            b_reg <= neg_out;
          end else begin
            b_reg <= b_reg;
          end
          state <= ITER;
        end
        ITER: begin
          // diff[N] set means the trial subtraction went negative: restore.
          if (!diff[N]) begin
            rem   <= diff;
            a_reg <= {a_reg[N-2:0], 1'b1};
          end else begin
            rem   <= shifted;
            a_reg <= {a_reg[N-2:0], 1'b0};
          end
          if (cnt == LAST_ITER) begin
            state <= NEG_Q;
          end else begin
            cnt   <= cnt + {{(CW-1){1'b0}}, 1'b1};
            state <= ITER;
          end
        end
        NEG_Q: begin
          if (sgn && (neg_a != neg_b)) begin
            a_reg <= neg_out;
          end else begin
            a_reg <= a_reg;
          end
          state <= NEG_R;
        end
        NEG_R: begin
          // Remainder takes the sign of the dividend; results are published
          // together so they are valid for the whole DONE cycle.
          quotient    <= a_reg;
          remainder   <= neg_a ? neg_out : rem[N-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// Self-checking bench for signed_div_seq (N = 32). A driver issues directed
// divisions and pushes the hand-computed result plus the cycle at which done
// must appear; an independent monitor pops and compares on every done pulse.
module tb_signed_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  signed_div_seq #(.N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient",    quotient,             mon_e.q);
        chk("remainder",   remainder,            mon_e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dz});
        chk("done_cycle",  32'(cyc),             32'(mon_e.cyc));
      end
    end
  end

  // mode 0: plain, 1: extra start mid-operation, 2: start during DONE,
  // 3: reset asserted mid-operation (no result expected)
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int mode);
    int   t;
    int   n;
    bit   idle;
    exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk);
    #1;
    t = cyc;
    // Scramble the inputs so that a design not latching them is caught.
    start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0000; is_signed = ~s;
    if (mode != 3) begin
      e.q = eq; e.r = er; e.dz = edz; e.cyc = t + ((b == 32'd0) ? 0 : 36);
      sb.push_back(e);
    end
    if (mode == 1) begin
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (mode == 3) begin
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_busy",      {31'd0, busy},        32'd0);
      chk("rst_done",      {31'd0, done},        32'd0);
      chk("rst_quotient",  quotient,             32'd0);
      chk("rst_remainder", remainder,            32'd0);
      chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (45) @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      return;
    end
    n = 0;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (mode == 2 && done) begin
          start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
        end
      end else begin
        start = 1'b0;
        idle = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("idle_reached", {31'd0, idle}, 32'd1);
    if (mode != 1) begin
      chk("busy_cycles", 32'(n), (b == 32'd0) ? 32'd1 : 32'd37);
    end
    if (mode == 2) begin
      @(negedge clk);
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy",      {31'd0, busy},        32'd0);
    chk("reset_done",      {31'd0, done},        32'd0);
    chk("reset_quotient",  quotient,             32'd0);
    chk("reset_remainder", remainder,            32'd0);
    chk("reset_dbz",       {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 0);
    issue(32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    issue(32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 0);
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 1'b0, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0, 0);
    issue(32'hFFFF_FFFF, 32'd16,        1'b0, 32'h0FFF_FFFF, 32'd15,        1'b0, 0);
    issue(32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1, 0);
    issue(32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0);
    issue(32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 1);

    // Results must hold while idle.
    repeat (5) @(negedge clk);
    chk("hold_quotient",  quotient,  32'd14);
    chk("hold_remainder", remainder, 32'd2);

    issue(32'd100,       32'd3,         1'b0, 32'd33,        32'd1,         1'b0, 2);
    issue(32'd100,       32'd7,         1'b0, 32'd0,         32'd0,         1'b0, 3);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signed_div_seq.md
SIGNED_DIV_SEQ -- requirements
Module: signed_div_seq

Interface
REQ-001 Parameter N, default 32, operand and result bit width (N >= 4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 dividend  input  N  numerator, captured on accepted start.
REQ-007 divisor  input  N  denominator, captured on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  single-cycle pulse, results valid.
REQ-010 quotient  output  N  result quotient, held until next accepted start.
REQ-011 remainder  output  N  result remainder, held until next accepted start.
REQ-012 div_by_zero  output  1  flag for the current result, held with the result.

Function
REQ-013 FSM states: IDLE, NEG_A, NEG_B, ITER, NEG_Q, NEG_R, DONE.
REQ-014 Accepted start = start high in IDLE at edge t; dividend, divisor and is_signed are latched at t.
REQ-015 start outside IDLE is ignored: no restart, no effect on the in-flight operation.
REQ-016 Divisor == 0 at accept: IDLE->DONE; quotient = all ones, remainder = dividend, div_by_zero = 1; done high in cycle t+1.
REQ-017 Normal path: NEG_A (t+1) -> NEG_B (t+2) -> ITER for exactly N cycles (t+3..t+N+2) -> NEG_Q (t+N+3) -> NEG_R (t+N+4) -> DONE (t+N+5).
REQ-018 Latency is fixed: done at t+N+5 for every nonzero divisor, regardless of operand signs.
REQ-019 One shared two's-complement negator serves every negation; each negation state drives it exactly once.
REQ-020 NEG_A replaces the dividend with its magnitude iff is_signed and dividend MSB = 1; otherwise the value is unchanged.
REQ-021 NEG_B does the same for the divisor.
REQ-022 ITER performs one restoring step per cycle on N-bit magnitudes with an N+1-bit partial remainder; no early termination.
REQ-023 NEG_Q negates the quotient iff is_signed and the operand signs differ.
REQ-024 NEG_R negates the remainder iff is_signed and the dividend was negative; the remainder sign follows the dividend.
REQ-025 Signed overflow (-2^(N-1) / -1) follows naturally: quotient = 0x80..0, remainder = 0, div_by_zero = 0.
REQ-026 DONE lasts one cycle and returns to IDLE; a start in that cycle is ignored; a start in the following IDLE cycle is accepted.
REQ-027 quotient, remainder and div_by_zero update only in DONE; between operations they hold their values.

Reset
REQ-028 rst_n low, at any time including mid-operation, forces IDLE immediately.
REQ-029 Reset clears busy, done, quotient, remainder, div_by_zero and all internal registers to 0.
REQ-030 After rst_n deasserts, the first accepted start is at the first rising edge with start high.

Structure
REQ-031 Package div_pkg holds the state encoding localparams (3-bit) and the iteration-counter width, $clog2(N)+1.
REQ-032 Sub-module: exactly one complement2 instance (parameter N), with its input muxed by state.
REQ-033 The FSM, counter and restoring datapath are internal to signed_div_seq; no further sub-modules.

Verification
REQ-034 Unsigned: 100 / 7, start at t -> quotient 14, remainder 2, div_by_zero 0, done at t+37 only.
REQ-035 Signed: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; the same operands unsigned -> quotient 0, remainder 0x80000000.
REQ-037 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, done at t+1, busy high for one cycle.
REQ-038 start pulsed at t+10 during 100/7 -> result unchanged, done at t+37; rst_n low at t+20 -> busy=0, outputs 0, no done pulse.
